// File: rtl/piso_serializer_pkg.sv
// ---------------------------------------------------------------------------
// piso_pkg
//   Shared types and helpers for the PISO serializer and its framing
//   sub-blocks.
//   - piso_state_e : the serializer's two FSM states
//   - cnt_w()      : bit-counter width for a given word width
// ---------------------------------------------------------------------------
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_e;

  // Width of a counter that must hold 0..width-1. A one-bit floor keeps the
  // counter legal for degenerate widths.
  function automatic int cnt_w(input int width);
    if (width < 2) begin
      return 1;
    end else begin
      return $clog2(width);
    end
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// ---------------------------------------------------------------------------
// piso_serializer_if
//   Load port plus serial port of the PISO serializer, bundled.
//   Signals:
//     load_valid / load_ready / load_data : parallel word handshake
//     serial_ready / serial_valid / serial_out : serial bit handshake
//     frame_start / frame_last : first / last bit markers
//     busy : a word is in flight
//   Modports:
//     slave  : the serializer's view
//     master : the view of the block driving loads and consuming bits
// ---------------------------------------------------------------------------
interface piso_serializer_if #(
  parameter int WIDTH = 4
);

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             serial_ready;
  logic             serial_valid;
  logic             serial_out;
  logic             frame_start;
  logic             frame_last;
  logic             busy;

  modport slave (
    input  load_valid,
    input  load_data,
    input  serial_ready,
    output load_ready,
    output serial_valid,
    output serial_out,
    output frame_start,
    output frame_last,
    output busy
  );

  modport master (
    output load_valid,
    output load_data,
    output serial_ready,
    input  load_ready,
    input  serial_valid,
    input  serial_out,
    input  frame_start,
    input  frame_last,
    input  busy
  );

endinterface

// File: rtl/piso_serializer_bit_counter.sv
// ---------------------------------------------------------------------------
// bit_counter
//   Saturating 0..MAX beat counter used for word framing.
//   Ports:
//     clk, reset_n : clock, asynchronous active-low reset
//     clr          : synchronous return to 0 (wins over en)
//     en           : advance by one; holds at MAX instead of wrapping
//     cnt          : current count (register output)
//     is_max       : cnt == MAX
// ---------------------------------------------------------------------------
module bit_counter
  import piso_pkg::*;
#(
  parameter int MAX = 3,
  parameter int CW  = cnt_w(MAX + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          is_max
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  logic [CW-1:0] cnt_r;

  // Count register: clear has priority, saturates at MAX.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (en && (cnt_r != MAX_C)) begin
      cnt_r <= cnt_r + ONE_C;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt    = cnt_r;
  assign is_max = (cnt_r == MAX_C);

endmodule

// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
//   Parallel-in, serial-out serializer. A WIDTH-bit word accepted on the
//   load handshake is shifted out MSB-first, one bit per serial beat
//   (serial_valid & serial_ready). A new word can be loaded on the last
//   beat of the current one for gap-free back-to-back streaming.
//   Ports:
//     clk     : clock, rising edge
//     reset_n : asynchronous active-low reset; aborts any word in flight
//     bus     : piso_serializer_if.slave (load and serial handshakes,
//               frame markers, busy)
// ---------------------------------------------------------------------------
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  piso_serializer_if.slave  bus
);

  localparam int CW = cnt_w(WIDTH);

  localparam logic [0:0]    ST_IDLE      = 1'(IDLE);
  localparam logic [0:0]    ST_SHIFT     = 1'(SHIFT);
  localparam logic [CW-1:0] CNT_PRE_LAST = CW'(WIDTH - 2);

  logic [0:0]       state_r;
  logic [WIDTH-1:0] shift_reg_r;
  logic             frame_start_r;
  logic             frame_last_r;

  logic [0:0]       state_nxt_s;
  logic [WIDTH-1:0] shift_nxt_s;
  logic             frame_start_nxt_s;
  logic             frame_last_nxt_s;
  logic             cnt_en_s;
  logic             cnt_clr_s;
  logic [CW-1:0]    bit_cnt_s;
  logic             cnt_max_s;
  logic             serial_valid_s;
  logic             beat_s;
  logic             load_ready_s;
  logic             load_fire_s;
  logic [WIDTH-1:0] shift_left_s;

  bit_counter #(
    .MAX (WIDTH - 1),
    .CW  (CW)
  ) u_bit_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (cnt_en_s),
    .clr     (cnt_clr_s),
    .cnt     (bit_cnt_s),
    .is_max  (cnt_max_s)
  );

  assign serial_valid_s = (state_r == ST_SHIFT);
  assign beat_s         = serial_valid_s & bus.serial_ready;
  // Ready depends only on state and serial_ready, never on load_valid.
  assign load_ready_s   = (state_r == ST_IDLE) | (frame_last_r & bus.serial_ready);
  assign load_fire_s    = bus.load_valid & load_ready_s;
  // Zero fill, so a word that drains fully leaves the register clear.
  assign shift_left_s   = {shift_reg_r[WIDTH-2:0], 1'b0};

  // Next-state, shift-register and frame-marker decode.
  always_comb begin
    state_nxt_s       = state_r;
    shift_nxt_s       = shift_reg_r;
    frame_start_nxt_s = frame_start_r;
    frame_last_nxt_s  = frame_last_r;
    cnt_en_s          = 1'b0;
    cnt_clr_s         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (load_fire_s) begin
          state_nxt_s       = ST_SHIFT;
          shift_nxt_s       = bus.load_data;
          frame_start_nxt_s = 1'b1;
          frame_last_nxt_s  = 1'b0;
          cnt_clr_s         = 1'b1;
        end else begin
          state_nxt_s       = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (beat_s) begin
          if (cnt_max_s) begin
            if (load_fire_s) begin
              // Reload on the last beat: next word's MSB follows with no gap.
              shift_nxt_s       = bus.load_data;
              frame_start_nxt_s = 1'b1;
              frame_last_nxt_s  = 1'b0;
              cnt_clr_s         = 1'b1;
            end else begin
              state_nxt_s       = ST_IDLE;
              shift_nxt_s       = shift_left_s;
              frame_start_nxt_s = 1'b0;
              frame_last_nxt_s  = 1'b0;
              cnt_clr_s         = 1'b1;
            end
          end else begin
            shift_nxt_s       = shift_left_s;
            frame_start_nxt_s = 1'b0;
            frame_last_nxt_s  = (bit_cnt_s == CNT_PRE_LAST);
            cnt_en_s          = 1'b1;
          end
        end else begin
          // Backpressure: everything holds.
          state_nxt_s = ST_SHIFT;
        end
      end
      default: begin
        state_nxt_s       = ST_IDLE;
        shift_nxt_s       = {WIDTH{1'b0}};
        frame_start_nxt_s = 1'b0;
        frame_last_nxt_s  = 1'b0;
        cnt_clr_s         = 1'b1;
      end
    endcase
  end

  // State, data and frame-marker registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      shift_reg_r   <= {WIDTH{1'b0}};
      frame_start_r <= 1'b0;
      frame_last_r  <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      shift_reg_r   <= shift_nxt_s;
      frame_start_r <= frame_start_nxt_s;
      frame_last_r  <= frame_last_nxt_s;
    end
  end

  assign bus.load_ready   = load_ready_s;
  assign bus.serial_valid = serial_valid_s;
  assign bus.serial_out   = shift_reg_r[WIDTH-1];
  assign bus.frame_start  = frame_start_r;
  assign bus.frame_last   = frame_last_r;
  assign bus.busy         = serial_valid_s;

endmodule

// File: tb/tb_piso_serializer.sv
// ---------------------------------------------------------------------------
// tb_piso_serializer
//   Directed bench for piso_serializer (WIDTH=4) with a SIPO loopback.
// ---------------------------------------------------------------------------
module tb_piso_serializer;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  logic [3:0] sipo;

  piso_serializer_if #(.WIDTH(4)) bus ();

  piso_serializer #(.WIDTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference SIPO: shifts in at the LSB on every serial beat.
  always @(posedge clk) begin
    if (bus.serial_valid && bus.serial_ready) begin
      sipo <= {sipo[2:0], bus.serial_out};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_beat(input string tag, input logic b, input logic fs,
                             input logic fl, input logic lr);
    chk({tag, ".valid"}, 32'(bus.serial_valid), 32'd1);
    chk({tag, ".out"},   32'(bus.serial_out),   32'(b));
    chk({tag, ".start"}, 32'(bus.frame_start),  32'(fs));
    chk({tag, ".last"},  32'(bus.frame_last),   32'(fl));
    chk({tag, ".ready"}, 32'(bus.load_ready),   32'(lr));
    chk({tag, ".busy"},  32'(bus.busy),         32'd1);
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, ".valid"}, 32'(bus.serial_valid), 32'd0);
    chk({tag, ".ready"}, 32'(bus.load_ready),   32'd1);
    chk({tag, ".busy"},  32'(bus.busy),         32'd0);
    chk({tag, ".out"},   32'(bus.serial_out),   32'd0);
    chk({tag, ".start"}, 32'(bus.frame_start),  32'd0);
    chk({tag, ".last"},  32'(bus.frame_last),   32'd0);
  endtask

  initial begin
    logic [3:0] w;
    logic [7:0] s;
    int beats;
    int cyc;
    checks = 0;
    errors = 0;
    sipo   = 4'd0;

    // 1. Reset held 3 cycles with load_valid high: nothing accepted.
    reset_n          = 1'b0;
    bus.load_valid   = 1'b1;
    bus.load_data    = 4'hF;
    bus.serial_ready = 1'b1;
    repeat (3) tick();
    expect_idle("reset");
    bus.load_valid = 1'b0;
    reset_n        = 1'b1;
    tick();
    expect_idle("post_reset");

    // 2. Single word 1011.
    bus.load_valid = 1'b1;
    bus.load_data  = 4'b1011;
    #1;
    chk("single.idle_ready", 32'(bus.load_ready), 32'd1);
    tick();
    bus.load_valid = 1'b0;
    bus.load_data  = 4'b0000;
    #1;
    w = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      expect_beat("single", w[3-i], (i == 0), (i == 3), (i == 3));
      tick();
    end
    expect_idle("single.end");

    // 3. Back-to-back 1100 then 0011: eight contiguous bits.
    bus.load_valid = 1'b1;
    bus.load_data  = 4'b1100;
    #1;
    tick();
    bus.load_data = 4'b0011;
    #1;
    s = 8'b1100_0011;
    for (int k = 0; k < 8; k++) begin
      expect_beat("b2b", s[7-k], (k % 4 == 0), (k % 4 == 3), (k % 4 == 3));
      tick();
      if (k == 3) begin
        bus.load_valid = 1'b0;
        #1;
      end
    end
    expect_idle("b2b.end");

    // 4. Backpressure on word 1001 after the second bit.
    bus.load_valid = 1'b1;
    bus.load_data  = 4'b1001;
    #1;
    tick();
    bus.load_valid = 1'b0;
    #1;
    expect_beat("bp.b0", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    expect_beat("bp.b1", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    bus.serial_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      expect_beat("bp.stall", 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    bus.serial_ready = 1'b1;
    #1;
    expect_beat("bp.b2", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    expect_beat("bp.b3", 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    expect_idle("bp.end");

    // 5. Asynchronous reset mid-word of 1110, then clean 0101.
    bus.load_valid = 1'b1;
    bus.load_data  = 4'b1110;
    #1;
    tick();
    bus.load_valid = 1'b0;
    #1;
    expect_beat("mid.b0", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    expect_beat("mid.b1", 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("mid.pre_reset_out", 32'(bus.serial_out), 32'd1);
    reset_n = 1'b0;
    #1;
    expect_idle("mid.async");
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    tick();
    expect_idle("mid.no_resume");
    bus.load_valid = 1'b1;
    bus.load_data  = 4'b0101;
    #1;
    tick();
    bus.load_valid = 1'b0;
    #1;
    w = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      expect_beat("mid.next", w[3-i], (i == 0), (i == 3), (i == 3));
      tick();
    end
    expect_idle("mid.end");

    // 6. Loopback through the SIPO with random words and random stalls.
    for (int n = 0; n < 100; n++) begin
      w = 4'($urandom_range(0, 15));
      bus.serial_ready = 1'b1;
      bus.load_valid   = 1'b1;
      bus.load_data    = w;
      #1;
      tick();
      bus.load_valid = 1'b0;
      beats = 0;
      cyc   = 0;
      while (beats < 4 && cyc < 40) begin
        bus.serial_ready = 1'($urandom_range(0, 1));
        #1;
        if (bus.serial_valid && bus.serial_ready) begin
          beats++;
        end
        tick();
        cyc++;
      end
      chk("loop.beats", 32'(beats), 32'd4);
      chk("loop.word", 32'(sipo), 32'(w));
    end
    bus.serial_ready = 1'b1;
    #1;
    expect_idle("loop.end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
